memoria_instrucao_carregavel: RTL and testbench

Parametrised, writable instruction memory that replaces the fixed combinational program ROM ahead of the fetch stage. After reset it accepts a program streamed word-by-word from the loader, then serves registered instruction fetches to the datapath. It adds stall support, an out-of-range NOP guard and HALT detection.

---
 rtl/memoria_instrucao_carregavel.sv | 112 +++++++++++
 tb/tb_memoria_instrucao_carregavel.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/memoria_instrucao_carregavel.sv
// rtl/memoria_instrucao_carregavel.sv - loadable instruction memory with registered fetch, stall and HALT detect
module memoria_instrucao_carregavel #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 12,
  parameter int                DEPTH    = 512,
  parameter logic [DATA_W-1:0] NOP_WORD = {5'd23, {(DATA_W-5){1'b0}}},
  parameter logic [4:0]        HALT_OP  = 5'd21
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              carga_valido,
  input  logic [DATA_W-1:0] carga_dado,
  input  logic              carga_fim,
  output logic              carga_pronto,
  output logic              erro_carga,
  output logic [ADDR_W:0]   palavras_carregadas,
  input  logic [ADDR_W-1:0] PC,
  input  logic              busca,
  input  logic              stall,
  output logic [DATA_W-1:0] INSTRUCAO,
  output logic              instrucao_valida,
  output logic              parada
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] UM      = (ADDR_W + 1)'(1);

  typedef enum logic {
    CARGA,
    EXECUCAO
  } estado_t;

  estado_t           estado;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dado_lido;
  logic              fonte_mem;
  logic              parada_reg;

  logic              cheia;
  logic              escrita;
  logic              busca_ok;
  logic              na_faixa;
  logic              halt_entregue;

  // palavras_carregadas doubles as the write pointer, so it saturates at DEPTH
  assign cheia    = (palavras_carregadas >= DEPTH_L);
  assign escrita  = !reset && (estado == CARGA) && carga_valido && !cheia;
  assign busca_ok = !reset && (estado == EXECUCAO) && busca && !stall;
  assign na_faixa = ({1'b0, PC} < palavras_carregadas) && ({1'b0, PC} < DEPTH_L);

  // Output word comes straight from registers: RAM read data or the NOP constant
  assign INSTRUCAO     = fonte_mem ? dado_lido : NOP_WORD;
  assign halt_entregue = instrucao_valida && (INSTRUCAO[DATA_W-1 -: 5] == HALT_OP);
  assign parada        = parada_reg || halt_entregue;

  // Loader write port; contents survive reset and are hidden by the word count
  always_ff @(posedge clock) begin
    if (escrita) begin
      mem[palavras_carregadas[IDX_W-1:0]] <= carga_dado;
    end
  end

  // Registered read port, only touched by an in-range accepted fetch
  always_ff @(posedge clock) begin
    if (busca_ok && na_faixa) begin
      dado_lido <= mem[PC[IDX_W-1:0]];
    end
  end

  // Load/execute control with its registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      estado              <= CARGA;
      carga_pronto        <= 1'b1;
      palavras_carregadas <= '0;
      erro_carga          <= 1'b0;
      instrucao_valida    <= 1'b0;
      fonte_mem           <= 1'b0;
      parada_reg          <= 1'b0;
    end else begin
      case (estado)
        CARGA: begin
          if (escrita) begin
            palavras_carregadas <= palavras_carregadas + UM;
          end else if (carga_valido) begin
            erro_carga <= 1'b1;
          end
          if (carga_fim) begin
            estado       <= EXECUCAO;
            carga_pronto <= 1'b0;
          end
        end
        EXECUCAO: begin
          if (!stall) begin
            instrucao_valida <= busca;
            if (busca) begin
              fonte_mem <= na_faixa;
            end
          end
          if (halt_entregue) begin
            parada_reg <= 1'b1;
          end
        end
        default: begin
          estado <= CARGA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memoria_instrucao_carregavel.sv
// tb/tb_memoria_instrucao_carregavel.sv - model-checked bench for the loadable instruction memory
module tb_memoria_instrucao_carregavel;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
  localparam logic [31:0] NOP  = 32'hB800_0000;
  localparam logic [31:0] HALT = 32'hA800_0000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              carga_valido = 1'b0;
  logic [DATA_W-1:0] carga_dado = '0;
  logic              carga_fim = 1'b0;
  logic              carga_pronto;
  logic              erro_carga;
  logic [ADDR_W:0]   palavras_carregadas;
  logic [ADDR_W-1:0] PC = '0;
  logic              busca = 1'b0;
  logic              stall = 1'b0;
  logic [DATA_W-1:0] INSTRUCAO;
  logic              instrucao_valida;
  logic              parada;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  memoria_instrucao_carregavel #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .carga_valido(carga_valido), .carga_dado(carga_dado), .carga_fim(carga_fim),
    .carga_pronto(carga_pronto), .erro_carga(erro_carga),
    .palavras_carregadas(palavras_carregadas),
    .PC(PC), .busca(busca), .stall(stall),
    .INSTRUCAO(INSTRUCAO), .instrucao_valida(instrucao_valida), .parada(parada)
  );

  always #5 clock = ~clock;

  // Reference model: program stored in an array, count of words, and flags
  logic [31:0] m_mem [DEPTH];
  int          m_cnt = 0;
  bit          m_exec = 1'b0;
  bit          m_err = 1'b0;
  bit          m_par = 1'b0;
  bit          m_val = 1'b0;
  logic [31:0] m_instr = NOP;

  always @(posedge clock) begin
    logic [31:0] w;
    if (reset) begin
      m_exec = 0; m_cnt = 0; m_err = 0; m_par = 0; m_val = 0; m_instr = NOP;
    end else if (!m_exec) begin
      if (carga_valido) begin
        if (m_cnt < DEPTH) begin
          m_mem[m_cnt] = carga_dado;
          m_cnt++;
        end else begin
          m_err = 1;
        end
      end
      if (carga_fim) m_exec = 1;
    end else if (!stall) begin
      if (busca) begin
        w = (int'(PC) < m_cnt) ? m_mem[int'(PC)] : NOP;
        m_instr = w;
        m_val = 1;
        if (w[31:27] == 5'd21) m_par = 1;
      end else begin
        m_val = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (checking) begin
      chk("m_pronto", 32'(carga_pronto), 32'(!m_exec));
      chk("m_erro", 32'(erro_carga), 32'(m_err));
      chk("m_palavras", 32'(palavras_carregadas), 32'(m_cnt));
      chk("m_valida", 32'(instrucao_valida), 32'(m_val));
      chk("m_instr", INSTRUCAO, m_instr);
      chk("m_parada", 32'(parada), 32'(m_par));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic load(input logic [31:0] w, input logic fim);
    carga_valido = 1; carga_dado = w; carga_fim = fim;
    tick();
    carga_valido = 0; carga_fim = 0;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] pc);
    busca = 1; PC = pc;
    tick();
  endtask

  initial begin
    reset = 1;
    tick();
    tick();
    checking = 1;
    reset = 0;
    chk("rst_pronto", 32'(carga_pronto), 32'd1);
    chk("rst_palavras", 32'(palavras_carregadas), 32'd0);
    chk("rst_instr", INSTRUCAO, NOP);
    chk("rst_valida", 32'(instrucao_valida), 32'd0);
    chk("rst_erro", 32'(erro_carga), 32'd0);
    chk("rst_parada", 32'(parada), 32'd0);

    load(32'h1, 0);
    load(32'h2, 0);
    load(32'h3, 1);
    chk("ld3_palavras", 32'(palavras_carregadas), 32'd3);
    chk("ld3_pronto", 32'(carga_pronto), 32'd0);

    fetch(0);  chk("f0", INSTRUCAO, 32'h1); chk("f0_v", 32'(instrucao_valida), 32'd1);
    fetch(1);  chk("f1", INSTRUCAO, 32'h2);
    fetch(2);  chk("f2", INSTRUCAO, 32'h3);
    fetch(3);  chk("f3_nop", INSTRUCAO, NOP); chk("f3_v", 32'(instrucao_valida), 32'd1);
    fetch(12'hFFF); chk("ffff_nop", INSTRUCAO, NOP);

    fetch(1);  chk("pre_stall", INSTRUCAO, 32'h2);
    stall = 1;
    fetch(3);  chk("stall1", INSTRUCAO, 32'h2); chk("stall1_v", 32'(instrucao_valida), 32'd1);
    fetch(0);  chk("stall2", INSTRUCAO, 32'h2);
    busca = 0; PC = 2; tick();
    chk("stall3", INSTRUCAO, 32'h2); chk("stall3_v", 32'(instrucao_valida), 32'd1);
    stall = 0;
    fetch(2);  chk("post_stall", INSTRUCAO, 32'h3);
    busca = 0; tick();
    chk("idle_v", 32'(instrucao_valida), 32'd0); chk("idle_hold", INSTRUCAO, 32'h3);

    load(32'hDEAD, 1);
    chk("exec_ignore", 32'(palavras_carregadas), 32'd3);

    reset = 1; tick(); reset = 0;
    chk("mid_rst_pronto", 32'(carga_pronto), 32'd1);
    chk("mid_rst_palavras", 32'(palavras_carregadas), 32'd0);
    chk("mid_rst_parada", 32'(parada), 32'd0);

    load(32'h11, 0);
    load(32'h22, 0);
    load(HALT, 0);
    load(32'h44, 0);
    load(32'h55, 0);
    load(32'h66, 1);
    chk("ovf_palavras", 32'(palavras_carregadas), 32'd4);
    chk("ovf_erro", 32'(erro_carga), 32'd1);

    fetch(3);  chk("ovf_f3", INSTRUCAO, 32'h44); chk("pre_halt", 32'(parada), 32'd0);
    fetch(2);  chk("halt_word", INSTRUCAO, HALT); chk("halt_set", 32'(parada), 32'd1);
    fetch(0);  chk("after_halt", INSTRUCAO, 32'h11); chk("halt_sticky", 32'(parada), 32'd1);
    fetch(4);  chk("f4_nop", INSTRUCAO, NOP);
    busca = 0; tick();
    chk("halt_sticky2", 32'(parada), 32'd1);

    reset = 1; tick(); reset = 0;
    chk("rst2_erro", 32'(erro_carga), 32'd0);
    chk("rst2_parada", 32'(parada), 32'd0);
    load(32'h77, 1);
    fetch(1);  chk("one_f1_nop", INSTRUCAO, NOP); chk("one_f1_v", 32'(instrucao_valida), 32'd1);
    fetch(0);  chk("one_f0", INSTRUCAO, 32'h77);
    busca = 0; tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
